// File: rtl/hpu_stream_pkg.sv
// Shared definitions for the hypervector stream-out path.
//   BEAT_W         : bits per output beat (width of stream_d)
//   beats_f(dim)   : beats per hypervector whose MSB index is dim
//   iw_f(dim)      : width of the beat-select index for that vector size
//   stream_state_t : sequencer states (IDLE, WAIT, SEND, DRAIN)
package hpu_stream_pkg;

    localparam int BEAT_W = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SEND  = 2'd2,
        DRAIN = 2'd3
    } stream_state_t;

    function automatic int beats_f(input int dim);
        return (dim + 1) / BEAT_W;
    endfunction

    // A one-beat vector still needs a 1-bit select.
    function automatic int iw_f(input int dim);
        return (beats_f(dim) > 1) ? $clog2(beats_f(dim)) : 1;
    endfunction

endpackage

// File: rtl/stream_out_ctrl.sv
// stream_out_ctrl: reads each finished hypervector out of the sign-bit
// buffer stage as BEATS beats of BEAT_W bits and presents them to the DMA
// write path, counting vectors per job and pulsing done at the end.
//
// Handshake: a beat transfers on a cycle where dst_valid && dst_ready.
// dst_valid/dst_last hold while dst_ready is low; a new beat is only
// requested from the buffer (stream_v) when the one-deep output register
// is empty or being drained the same cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   run, vec_num    job start (sampled in IDLE) and vector count
//   result_valid    upstream sign bits final and stable (level)
//   result_ack      one-cycle pulse, current vector fully captured
//   stream_v        capture strobe to the buffer stage
//   stream_i        beat select, driven with stream_v
//   dst_ready       sink ready
//   dst_valid       stream_d holds a valid beat
//   dst_last        final beat of the job
//   busy            any state other than IDLE
//   done            one-cycle pulse at job completion
//   stall_cycles    (STREAM_OUT_STALL_CNT_EN only) saturating count of
//                   cycles with dst_valid && !dst_ready
//   state           current sequencer state, for observation
//
// Build option: define STREAM_OUT_STALL_CNT_EN to add stall_cycles.
module stream_out_ctrl
    import hpu_stream_pkg::*;
#(
    parameter int DIM = 1023,
    parameter int VW  = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [VW-1:0]         vec_num,
    input  logic                  result_valid,
    output logic                  result_ack,
    output logic                  stream_v,
    output logic [iw_f(DIM)-1:0]  stream_i,
    input  logic                  dst_ready,
    output logic                  dst_valid,
    output logic                  dst_last,
    output logic                  busy,
    output logic                  done,
`ifdef STREAM_OUT_STALL_CNT_EN
    output logic [31:0]           stall_cycles,
`endif
    output stream_state_t         state
);

    localparam int BEATS = beats_f(DIM);
    localparam int IW    = iw_f(DIM);
    localparam logic [IW-1:0] LAST_BEAT = IW'(BEATS - 1);

    stream_state_t state_q, state_d;
    logic [IW-1:0] beat_q, beat_d;
    logic [VW-1:0] vec_cnt_q, vec_cnt_d;
    logic [VW-1:0] vec_num_q, vec_num_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          can_issue;
    logic          issue;
    logic          ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            vec_cnt_q <= '0;
            vec_num_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            vec_cnt_q <= vec_cnt_d;
            vec_num_q <= vec_num_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        vec_cnt_d = vec_cnt_q;
        vec_num_d = vec_num_q;
        valid_d   = valid_q;
        last_d    = last_q;
        done_d    = 1'b0;
        issue     = 1'b0;
        ack       = 1'b0;
        can_issue = !valid_q || dst_ready;

        // Output register empties on acceptance; an issue below refills it.
        if (valid_q && dst_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (run) begin
                    if (vec_num != '0) begin
                        vec_num_d = vec_num;
                        vec_cnt_d = '0;
                        beat_d    = '0;
                        state_d   = WAIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (result_valid) begin
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // A dropped result_valid simply pauses at the held beat.
                if (result_valid && can_issue) begin
                    issue   = 1'b1;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    if (beat_q == LAST_BEAT) begin
                        ack       = 1'b1;
                        beat_d    = '0;
                        vec_cnt_d = vec_cnt_q + VW'(1);
                        if ((vec_cnt_q + VW'(1)) == vec_num_q) begin
                            last_d  = 1'b1;
                            state_d = DRAIN;
                        end else begin
                            state_d = WAIT;
                        end
                    end else begin
                        beat_d = beat_q + IW'(1);
                    end
                end
            end
            DRAIN: begin
                // Only the job's final beat can be in the register here.
                if (valid_q && dst_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stream_v   = issue;
    assign stream_i   = beat_q;
    assign result_ack = ack;
    assign dst_valid  = valid_q;
    assign dst_last   = last_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign state      = state_q;

`ifdef STREAM_OUT_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == IDLE && run) begin
            stall_q <= '0;
        end else if (valid_q && !dst_ready && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_stream_out_ctrl.sv
// Directed bench for stream_out_ctrl (default DIM=1023: 4 beats/vector).
// A negedge monitor tracks beat order, handshakes, acks and done pulses;
// each test task drives one scenario and checks its own cycle timing.
// Build with STREAM_OUT_STALL_CNT_EN defined to include the stall test.
module tb_stream_out_ctrl;
    import hpu_stream_pkg::*;

    localparam int VW = 26;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [VW-1:0] vec_num;
    logic          result_valid;
    logic          result_ack;
    logic          stream_v;
    logic [1:0]    stream_i;
    logic          dst_ready;
    logic          dst_valid;
    logic          dst_last;
    logic          busy;
    logic          done;
    stream_state_t dut_state;
`ifdef STREAM_OUT_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // monitor bookkeeping
    int         job_beats = 0;
    int         hs_cnt = 0;
    int         issue_cnt = 0;
    int         ack_cnt = 0;
    int         done_cnt = 0;
    int         last_cnt = 0;
    logic [1:0] exp_beat = 2'd0;
    bit         prev_block = 1'b0;
    logic       prev_last = 1'b0;

    // upstream result_valid model
    bit up_en = 1'b0;
    int up_gap = 0;
    int gap_left = 0;
    bit ack_seen = 1'b0;

    stream_out_ctrl #(.DIM(1023), .VW(VW)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .vec_num      (vec_num),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .stream_v     (stream_v),
        .stream_i     (stream_i),
        .dst_ready    (dst_ready),
        .dst_valid    (dst_valid),
        .dst_last     (dst_last),
        .busy         (busy),
        .done         (done),
`ifdef STREAM_OUT_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .state        (dut_state)
    );

    always #5 clk = ~clk;

    // Upstream: raise result_valid, drop it after the ack, raise it again
    // up_gap+2 cycles after the ack.
    initial begin
        result_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !up_en) begin
                result_valid = 1'b0;
                gap_left     = 0;
            end else if (ack_seen) begin
                result_valid = 1'b0;
                gap_left     = up_gap;
                ack_seen     = 1'b0;
            end else if (!result_valid) begin
                if (gap_left == 0) result_valid = 1'b1;
                else gap_left--;
            end
        end
    end

    // Stream monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (stream_v) begin
                checks++;
                if (stream_i !== exp_beat) begin
                    errors++;
                    $display("FAIL beat_order: stream_i=%0d expected %0d", stream_i, exp_beat);
                end
                checks++;
                if (result_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL issue_without_result_valid: stream_v=1 result_valid=%b", result_valid);
                end
                exp_beat = exp_beat + 2'd1;
                issue_cnt++;
            end
            if (result_ack) begin
                ack_cnt++;
                ack_seen = 1'b1;
                checks++;
                if (stream_v !== 1'b1 || stream_i !== 2'd3) begin
                    errors++;
                    $display("FAIL ack_timing: stream_v=%b stream_i=%0d expected 1/3", stream_v, stream_i);
                end
            end
            if (dst_valid && !dst_ready) begin
                checks++;
                if (stream_v !== 1'b0) begin
                    errors++;
                    $display("FAIL issue_while_blocked: stream_v=%b expected 0", stream_v);
                end
            end
            if (!dst_valid) begin
                checks++;
                if (dst_last !== 1'b0) begin
                    errors++;
                    $display("FAIL last_without_valid: dst_last=%b expected 0", dst_last);
                end
            end
            if (prev_block) begin
                checks++;
                if (dst_valid !== 1'b1 || dst_last !== prev_last) begin
                    errors++;
                    $display("FAIL hold_stable: dst_valid=%b dst_last=%b expected 1/%b", dst_valid, dst_last, prev_last);
                end
            end
            if (dst_valid && dst_ready) begin
                hs_cnt++;
                if (dst_last) last_cnt++;
                checks++;
                if (dst_last !== (hs_cnt == job_beats)) begin
                    errors++;
                    $display("FAIL last_flag: handshake %0d dst_last=%b expected %b", hs_cnt, dst_last, hs_cnt == job_beats);
                end
            end
            if (done) done_cnt++;
            prev_block = dst_valid && !dst_ready;
            prev_last  = dst_last;
        end else begin
            prev_block = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prep_job(input int beats);
        job_beats = beats;
        hs_cnt    = 0;
        issue_cnt = 0;
        ack_cnt   = 0;
        done_cnt  = 0;
        last_cnt  = 0;
        exp_beat  = 2'd0;
        ack_seen  = 1'b0;
    endtask

    task automatic finish_test();
        up_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; vec_num = '0; dst_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (dut_state !== IDLE || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d busy=%b done=%b expected IDLE/0/0", dut_state, busy, done);
        end
        checks++;
        if (stream_v !== 1'b0 || dst_valid !== 1'b0 || dst_last !== 1'b0 || result_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: stream_v=%b dst_valid=%b dst_last=%b result_ack=%b expected 0",
                     stream_v, dst_valid, dst_last, result_ack);
        end
        rst = 1'b0;
        tick();
    endtask

    // run at cycle 0; WAIT at 1; issues 2..5; dst_valid 3..6; done at 7
    task automatic test_single();
        bit e_sv, e_dv, e_dl, e_ack, e_done, e_busy;
        prep_job(4);
        up_gap    = 0;
        dst_ready = 1'b1;
        @(negedge clk);
        up_en = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            run     = (c == 0);
            vec_num = 26'd1;
            @(negedge clk);
            e_sv   = (c >= 2 && c <= 5);
            e_dv   = (c >= 3 && c <= 6);
            e_dl   = (c == 6);
            e_ack  = (c == 5);
            e_done = (c == 7);
            e_busy = (c >= 1 && c <= 6);
            checks++;
            if (stream_v !== e_sv || dst_valid !== e_dv || dst_last !== e_dl ||
                result_ack !== e_ack || done !== e_done || busy !== e_busy) begin
                errors++;
                $display("FAIL single_c%0d: sv=%b dv=%b dl=%b ack=%b done=%b busy=%b expected %b%b%b%b%b%b",
                         c, stream_v, dst_valid, dst_last, result_ack, done, busy,
                         e_sv, e_dv, e_dl, e_ack, e_done, e_busy);
            end
        end
        checks++;
        if (hs_cnt != 4 || issue_cnt != 4 || ack_cnt != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL single_totals: hs=%0d issue=%0d ack=%0d done=%0d expected 4/4/1/1",
                     hs_cnt, issue_cnt, ack_cnt, done_cnt);
        end
        finish_test();
    endtask

    // Beat 1 sits in the register at cycle 4; sink stalls cycles 4..6.
    task automatic test_backpressure();
        prep_job(4);
        up_gap    = 0;
        dst_ready = 1'b1;
        @(negedge clk);
        up_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            run       = (c == 0);
            vec_num   = 26'd1;
            dst_ready = !(c >= 4 && c <= 6);
            @(negedge clk);
            if (c >= 4 && c <= 6) begin
                checks++;
                if (stream_v !== 1'b0 || dst_valid !== 1'b1 || dst_last !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_blocked_c%0d: sv=%b dv=%b dl=%b expected 0/1/0", c, stream_v, dst_valid, dst_last);
                end
            end
            if (c == 7) begin
                checks++;
                if (stream_v !== 1'b1 || stream_i !== 2'd2) begin
                    errors++;
                    $display("FAIL bp_resume: stream_v=%b stream_i=%0d expected 1/2", stream_v, stream_i);
                end
            end
            if (c == 9) begin
                checks++;
                if (dst_valid !== 1'b1 || dst_last !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_last_beat: dv=%b dl=%b expected 1/1", dst_valid, dst_last);
                end
            end
            if (c == 10) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_done: done=%b expected 1", done);
                end
            end
        end
        checks++;
        if (hs_cnt != 4 || issue_cnt != 4 || ack_cnt != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL bp_totals: hs=%0d issue=%0d ack=%0d done=%0d expected 4/4/1/1",
                     hs_cnt, issue_cnt, ack_cnt, done_cnt);
        end
        finish_test();
    endtask

    task automatic test_multi_vector();
        prep_job(12);
        up_gap    = 3;
        dst_ready = 1'b1;
        @(negedge clk);
        up_en = 1'b1;
        tick();
        run     = 1'b1;
        vec_num = 26'd3;
        tick();
        run = 1'b0;
        wait_done("multi", 300);
        checks++;
        if (hs_cnt != 12 || issue_cnt != 12 || ack_cnt != 3 || done_cnt != 1 || last_cnt != 1) begin
            errors++;
            $display("FAIL multi_totals: hs=%0d issue=%0d ack=%0d done=%0d last=%0d expected 12/12/3/1/1",
                     hs_cnt, issue_cnt, ack_cnt, done_cnt, last_cnt);
        end
        finish_test();
    endtask

    task automatic test_zero_vectors();
        prep_job(0);
        up_en     = 1'b0;
        dst_ready = 1'b1;
        tick();
        run     = 1'b1;
        vec_num = '0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_c0: done=%b busy=%b expected 0/0", done, busy);
        end
        tick();
        run = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b expected 1/0", done, busy);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || stream_v !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL zero_after_c%0d: busy=%b stream_v=%b done=%b expected 0", c, busy, stream_v, done);
            end
        end
        finish_test();
    endtask

    task automatic test_reset_mid_job();
        int n = 0;
        bit hit = 1'b0;
        prep_job(12);
        up_gap    = 3;
        dst_ready = 1'b1;
        @(negedge clk);
        up_en = 1'b1;
        tick();
        run     = 1'b1;
        vec_num = 26'd3;
        tick();
        run = 1'b0;
        // find the issue of beat 2 of vector 2
        while (!hit && n < 100) begin
            @(negedge clk);
            n++;
            hit = (stream_v === 1'b1 && stream_i === 2'd2 && ack_cnt == 1);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midreset_timeout: beat 2 of vector 2 not seen in %0d cycles", n);
        end
        rst   = 1'b1;
        up_en = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_state !== IDLE || busy !== 1'b0 || stream_v !== 1'b0 || dst_valid !== 1'b0 ||
            dst_last !== 1'b0 || result_ack !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: state=%0d busy=%b sv=%b dv=%b dl=%b ack=%b done=%b expected IDLE/0",
                     dut_state, busy, stream_v, dst_valid, dst_last, result_ack, done);
        end
        rst = 1'b0;
        tick();
        tick();
        // new single-vector job after the reset
        prep_job(4);
        up_gap = 0;
        @(negedge clk);
        up_en = 1'b1;
        tick();
        run     = 1'b1;
        vec_num = 26'd1;
        tick();
        run = 1'b0;
        wait_done("midreset_rerun", 100);
        checks++;
        if (hs_cnt != 4 || ack_cnt != 1 || done_cnt != 1 || last_cnt != 1) begin
            errors++;
            $display("FAIL midreset_rerun_totals: hs=%0d ack=%0d done=%0d last=%0d expected 4/1/1/1",
                     hs_cnt, ack_cnt, done_cnt, last_cnt);
        end
        finish_test();
    endtask

`ifdef STREAM_OUT_STALL_CNT_EN
    // Beat 0 is registered at cycle 3; sink stalls cycles 3..9 (7 cycles).
    task automatic test_stall_count();
        prep_job(4);
        up_gap    = 0;
        dst_ready = 1'b1;
        @(negedge clk);
        up_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            run       = (c == 0);
            vec_num   = 26'd1;
            dst_ready = !(c >= 3 && c <= 9);
        end
        wait_done("stall", 50);
        checks++;
        if (stall_cycles !== 32'd7) begin
            errors++;
            $display("FAIL stall_count: stall_cycles=%0d expected 7", stall_cycles);
        end
        up_en = 1'b0;
        tick();
        run     = 1'b1;
        vec_num = 26'd1;
        tick();
        run = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL stall_clear_on_run: stall_cycles=%0d expected 0", stall_cycles);
        end
        // job left waiting for result_valid; clear it
        rst = 1'b1;
        tick();
        rst = 1'b0;
        finish_test();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        vec_num   = '0;
        dst_ready = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_multi_vector();
        test_zero_vectors();
        test_reset_mid_job();
`ifdef STREAM_OUT_STALL_CNT_EN
        test_stall_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
